// File: rtl/mem_resp_model.sv
// Memory-system responder model: word storage behind a one-line (4-word) read buffer.
// Buffer hits and illegal requests complete in the request cycle; misses and writes take MISS_LAT cycles.
module mem_resp_model #(
    parameter int MISS_LAT = 4,
    parameter int MEM_AW   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int         DEPTH    = 1 << MEM_AW;
    localparam logic [3:0] LOAD_CNT = 4'(MISS_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:1] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        isWr_q, isWr_d;
    logic        bufValid_q, bufValid_d;
    logic [12:0] bufTag_q, bufTag_d;
    logic [15:0] lineBuf [4];

    // Storage starts zeroed and deliberately has no reset.
    logic [15:0] mem [DEPTH] = '{default: '0};

    logic illegal;
    logic hit;
    logic finish;

    assign illegal = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
    assign hit     = Rd & ~illegal & bufValid_q & (bufTag_q == Addr[15:3]);
    assign finish  = (state_q == BUSY) && (cnt_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        isWr_d     = isWr_q;
        bufValid_d = bufValid_q;
        bufTag_d   = bufTag_q;
        DataOut    = '0;
        Done       = 1'b0;
        Stall      = 1'b0;
        CacheHit   = 1'b0;
        err        = 1'b0;
        case (state_q)
            IDLE: begin
                if (illegal) begin
                    err  = 1'b1;
                    Done = 1'b1;
                end else if (hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    DataOut  = lineBuf[Addr[2:1]];
                end else if (Rd | Wr) begin
                    Stall   = 1'b1;
                    addr_d  = Addr[15:1];
                    data_d  = DataIn;
                    isWr_d  = Wr;
                    cnt_d   = LOAD_CNT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    Stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    Done    = 1'b1;
                    state_d = IDLE;
                    if (!isWr_q) begin
                        DataOut    = mem[addr_q[MEM_AW:1]];
                        bufValid_d = 1'b1;
                        bufTag_d   = addr_q[15:3];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are forced quiet for as long as reset is held.
        if (rst) begin
            DataOut  = '0;
            Done     = 1'b0;
            Stall    = 1'b0;
            CacheHit = 1'b0;
            err      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            isWr_q     <= 1'b0;
            bufValid_q <= 1'b0;
            bufTag_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            isWr_q     <= isWr_d;
            bufValid_q <= bufValid_d;
            bufTag_q   <= bufTag_d;
        end
    end

    // finish is low during reset (state_q is forced IDLE), so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (finish) begin
            if (isWr_q) begin
                mem[addr_q[MEM_AW:1]] <= data_q;
                if (bufValid_q && (bufTag_q == addr_q[15:3]))
                    lineBuf[addr_q[2:1]] <= data_q;
            end else begin
                for (int i = 0; i < 4; i++)
                    lineBuf[i] <= mem[{addr_q[MEM_AW:3], 2'(i)}];
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_model.sv
// Directed self-checking bench for mem_resp_model with MISS_LAT=4, MEM_AW=10.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_resp_model;

    logic        clk;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

    int errors = 0;
    int checks = 0;

    int          lat;
    int          stallCnt;
    logic [15:0] dout;
    logic        hitSeen;
    logic        errSeen;

    mem_resp_model #(.MISS_LAT(4), .MEM_AW(10)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request and waits (bounded) for Done; lat stays -1 on timeout.
    task automatic applyStimulus(input logic rdIn, input logic wrIn, input logic [15:0] addrIn,
                                 input logic [15:0] dataIn);
        @(posedge clk);
        #1;
        Rd = rdIn; Wr = wrIn; Addr = addrIn; DataIn = dataIn;
        lat = -1; stallCnt = 0; dout = '0; hitSeen = 1'b0; errSeen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (Stall) stallCnt++;
            if (Done) begin
                lat = c; dout = DataOut; hitSeen = CacheHit; errSeen = err;
                break;
            end
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = 16'h0;
        #12;
        checks++;
        if ({DataOut, Done, Stall, CacheHit, err} !== 20'h0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", {DataOut, Done, Stall, CacheHit, err});
        end
        @(negedge clk);
        Rd = 1'b0; rst = 1'b0;
        idleCycle();
        checks++;
        if ({DataOut, Done, Stall, CacheHit, err} !== 20'h0) begin
            errors++; $display("[TB] FAIL idle_outputs: got %h expected 0", {DataOut, Done, Stall, CacheHit, err});
        end
    endtask

    task automatic test_write_miss();
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1234);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL wr_latency: got %0d expected 4", lat); end
        checks++; if (stallCnt !== 4) begin errors++; $display("[TB] FAIL wr_stall_cycles: got %0d expected 4", stallCnt); end
        checks++; if (hitSeen !== 1'b0) begin errors++; $display("[TB] FAIL wr_cachehit: got %b expected 0", hitSeen); end
        checks++; if (errSeen !== 1'b0) begin errors++; $display("[TB] FAIL wr_err: got %b expected 0", errSeen); end
        checks++; if (dout !== 16'h0) begin errors++; $display("[TB] FAIL wr_dataout: got %h expected 0000", dout); end
        idleCycle();
        checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse: got %b expected 0", Done); end
    endtask

    task automatic test_read_miss_hit();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL rd_miss_latency: got %0d expected 4", lat); end
        checks++; if (dout !== 16'h1234) begin errors++; $display("[TB] FAIL rd_miss_data: got %h expected 1234", dout); end
        checks++; if (hitSeen !== 1'b0) begin errors++; $display("[TB] FAIL rd_miss_hit: got %b expected 0", hitSeen); end
        applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0);
        checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL rd_hit_latency: got %0d expected 0", lat); end
        checks++; if (hitSeen !== 1'b1) begin errors++; $display("[TB] FAIL rd_hit_flag: got %b expected 1", hitSeen); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("[TB] FAIL rd_hit_data: got %h expected 0000", dout); end
        checks++; if (stallCnt !== 0) begin errors++; $display("[TB] FAIL rd_hit_stall: got %0d expected 0", stallCnt); end
        idleCycle();
    endtask

    task automatic test_write_through();
        applyStimulus(1'b0, 1'b1, 16'h0014, 16'hBEEF);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL wt_latency: got %0d expected 4", lat); end
        checks++; if (hitSeen !== 1'b0) begin errors++; $display("[TB] FAIL wt_cachehit: got %b expected 0", hitSeen); end
        applyStimulus(1'b1, 1'b0, 16'h0014, 16'h0);
        checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL wt_hit_latency: got %0d expected 0", lat); end
        checks++; if (dout !== 16'hBEEF) begin errors++; $display("[TB] FAIL wt_hit_data: got %h expected beef", dout); end
        applyStimulus(1'b1, 1'b0, 16'h0018, 16'h0);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL next_line_latency: got %0d expected 4", lat); end
        checks++; if (stallCnt !== 4) begin errors++; $display("[TB] FAIL next_line_stall: got %0d expected 4", stallCnt); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("[TB] FAIL next_line_data: got %h expected 0000", dout); end
        idleCycle();
    endtask

    task automatic test_illegal();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);
        checks++; if (dout !== 16'h1234) begin errors++; $display("[TB] FAIL ill_preload_data: got %h expected 1234", dout); end
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'hFFFF);
        checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL rdwr_latency: got %0d expected 0", lat); end
        checks++; if (errSeen !== 1'b1) begin errors++; $display("[TB] FAIL rdwr_err: got %b expected 1", errSeen); end
        checks++; if (dout !== 16'h0) begin errors++; $display("[TB] FAIL rdwr_data: got %h expected 0000", dout); end
        checks++; if (stallCnt !== 0) begin errors++; $display("[TB] FAIL rdwr_stall: got %0d expected 0", stallCnt); end
        applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0);
        checks++; if (errSeen !== 1'b1) begin errors++; $display("[TB] FAIL odd_rd_err: got %b expected 1", errSeen); end
        checks++; if (hitSeen !== 1'b0) begin errors++; $display("[TB] FAIL odd_rd_hit: got %b expected 0", hitSeen); end
        applyStimulus(1'b0, 1'b1, 16'h0013, 16'hFFFF);
        checks++; if (errSeen !== 1'b1) begin errors++; $display("[TB] FAIL odd_wr_err: got %b expected 1", errSeen); end
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);
        checks++; if (lat !== 0 || hitSeen !== 1'b1) begin errors++; $display("[TB] FAIL post_err_hit: got lat=%0d hit=%b expected lat=0 hit=1", lat, hitSeen); end
        checks++; if (dout !== 16'h1234) begin errors++; $display("[TB] FAIL post_err_data: got %h expected 1234", dout); end
        applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0);
        checks++; if (dout !== 16'h0000 || errSeen !== 1'b0) begin errors++; $display("[TB] FAIL odd_wr_no_store: got %h err=%b expected 0000 err=0", dout, errSeen); end
        idleCycle();
    endtask

    task automatic test_reset_midbusy();
        @(posedge clk);
        #1;
        Wr = 1'b1; Rd = 1'b0; Addr = 16'h0020; DataIn = 16'h5555;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({DataOut, Done, Stall, CacheHit, err} !== 20'h0) begin
            errors++; $display("[TB] FAIL midbusy_reset_outputs: got %h expected 0", {DataOut, Done, Stall, CacheHit, err});
        end
        Wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL discard_latency: got %0d expected 4", lat); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("[TB] FAIL discard_data: got %h expected 0000", dout); end
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);
        checks++; if (lat !== 4 || hitSeen !== 1'b0) begin errors++; $display("[TB] FAIL invalidate_miss: got lat=%0d hit=%b expected lat=4 hit=0", lat, hitSeen); end
        checks++; if (dout !== 16'h1234) begin errors++; $display("[TB] FAIL invalidate_data: got %h expected 1234", dout); end
        idleCycle();
    endtask

    task automatic test_latched_request();
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0);
        @(posedge clk);
        #1;
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = 16'h0;
        @(negedge clk);
        checks++; if (Stall !== 1'b1) begin errors++; $display("[TB] FAIL latch_req_stall: got %b expected 1", Stall); end
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b1; Addr = 16'h0020; DataIn = 16'hAAAA;
        lat = -1; dout = '0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (Done) begin lat = c; dout = DataOut; break; end
        end
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL latch_latency: got %0d expected 4", lat); end
        checks++; if (dout !== 16'h1234) begin errors++; $display("[TB] FAIL latch_data: got %h expected 1234", dout); end
        idleCycle();
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0);
        checks++; if (dout !== 16'h0000) begin errors++; $display("[TB] FAIL latch_no_write: got %h expected 0000", dout); end
        applyStimulus(1'b1, 1'b0, 16'h0810, 16'h0);
        checks++; if (lat !== 4 || hitSeen !== 1'b0) begin errors++; $display("[TB] FAIL alias_miss: got lat=%0d hit=%b expected lat=4 hit=0", lat, hitSeen); end
        checks++; if (dout !== 16'h1234) begin errors++; $display("[TB] FAIL alias_data: got %h expected 1234", dout); end
        idleCycle();
    endtask

    initial begin
        test_reset();
        test_write_miss();
        test_read_miss_hit();
        test_write_through();
        test_illegal();
        test_reset_midbusy();
        test_latched_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
